// File: rtl/apb_regfile_slave.sv
// APB completer fronting a DEPTH x 8-bit register file on the 4-bit-address / 8-bit-data bus.
// Latency: completes WAIT_CYCLES+1 edges after the setup edge (1 edge when APB_SLV_WAIT_EN is undefined).
// Backpressure: holds pready low through the wait states; addresses >= DEPTH complete with pslverr.
//
// Optional feature macro: APB_SLV_WAIT_EN builds the wait-state counter and honours WAIT_CYCLES.
// Without it the counter is absent and every access completes with zero wait states.
//
// Ports:
//   pclk, rst_n          bus clock, asynchronous active-low reset
//   paddr, pwrite        register address and direction (1 = write), held by master until completion
//   psel, penable        select and access-phase qualifier
//   pwdata               write data
//   prdata               read data, 8'h00 outside a mapped read access
//   pready, pslverr      transfer-done strobe and out-of-range error (valid with pready only)
module apb_regfile_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [3:0] paddr,
  input  logic       pwrite,
  input  logic       psel,
  input  logic       penable,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state_d, state_q;
  logic       addr_ok;
  logic       cnt_zero;
  logic       wr_en;
  logic [7:0] rd_mux;
  logic [7:0] regs_q [DEPTH];

  // Address range check done at full integer width so DEPTH=16 does not wrap.
  assign addr_ok = (32'(paddr) < 32'(DEPTH));

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_d, cnt_q;

  assign cnt_zero = (cnt_q == 4'd0);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cnt_zero = 1'b1;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pready  = (state_q == ACCESS) && psel && penable && cnt_zero;
  assign pslverr = pready && !addr_ok;
  assign wr_en   = pready && pwrite && addr_ok;

  always_comb begin
    state_d = state_q;
`ifdef APB_SLV_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // psel & penable without a setup phase is a protocol violation and is ignored.
        if (psel && !penable) begin
          state_d = ACCESS;
`ifdef APB_SLV_WAIT_EN
          cnt_d   = 4'(WAIT_CYCLES);
`endif
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: no write, no error.
          state_d = IDLE;
        end else if (!penable) begin
          // A new setup phase restarts the wait period.
          state_d = ACCESS;
`ifdef APB_SLV_WAIT_EN
          cnt_d   = 4'(WAIT_CYCLES);
`endif
        end else if (pready) begin
          state_d = IDLE;
        end else begin
`ifdef APB_SLV_WAIT_EN
          // Saturating countdown; pready releases once it hits zero.
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-register decode avoids indexing the array with an out-of-range paddr.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (paddr == 4'(i))) begin
          regs_q[i] <= pwdata;
        end
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (paddr == 4'(i)) begin
        rd_mux = regs_q[i];
      end
    end
  end

  // Read data is driven for the whole access phase so it is stable at the completion edge.
  assign prdata = ((state_q == ACCESS) && psel && penable && !pwrite && addr_ok) ? rd_mux : 8'h00;

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic       pclk;
  logic       rst_n;
  logic [3:0] paddr;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata, prdata8;
  logic       pready, pready8;
  logic       pslverr, pslverr8;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rd_dat, rd_dat8;
  logic       rd_err, rd_err8;
  int         rd_lat;

  // Full-depth instance carries most checks; the DEPTH=8 instance sees the same
  // bus traffic and is used for the unmapped-address checks.
  apb_regfile_slave #(.DEPTH(16), .WAIT_CYCLES(2)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_regfile_slave #(.DEPTH(8), .WAIT_CYCLES(2)) u_dut8 (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata8), .pready(pready8), .pslverr(pslverr8)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Runs one transfer starting just after a rising edge. keep=1 leaves psel high
  // so the next call forms a back-to-back transfer; keep=0 inserts one idle clock.
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d, input bit keep);
    int n;
    bit got;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0; got = 1'b0;
    rd_dat = 8'hxx; rd_err = 1'bx; rd_dat8 = 8'hxx; rd_err8 = 1'bx;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge pclk);
      if (pready) begin
        got = 1'b1;
        rd_dat = prdata; rd_err = pslverr; rd_dat8 = prdata8; rd_err8 = pslverr8;
      end
      @(posedge pclk);
      n++;
    end
    rd_lat = n;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL xfer_timeout addr=%0d: pready never seen within 40 clocks (required high)", a);
    end
    #1;
    penable = 1'b0;
    if (!keep) begin
      psel = 1'b0;
      @(posedge pclk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'd0; pwdata = 8'h00;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    n_vec++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h, need 0/0/00", pready, pslverr, prdata);
    end
    rst_n = 1'b1;
    @(posedge pclk); #1;
    for (int a = 0; a < 16; a++) begin
      xfer(1'b0, 4'(a), 8'h00, 1'b0);
      n_vec++;
      if (rd_dat !== 8'h00 || rd_err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got data=%h err=%b, need 00/0", a, rd_dat, rd_err);
      end
    end
  endtask

  task automatic test_write_read(input bit b2b);
    logic [7:0] vals [4];
    vals[0] = 8'd5; vals[1] = 8'd10; vals[2] = 8'd5; vals[3] = 8'd10;
    // Clear first so a dropped write in this pass cannot be masked by an earlier one.
    for (int i = 0; i < 4; i++) xfer(1'b1, 4'(i + 2), 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 4'(i + 2), vals[i], b2b && (i != 3));
      n_vec++;
      if (rd_lat !== EXP_LAT || rd_err !== 1'b0) begin
        n_err++;
        $display("FAIL wr_lat b2b=%0d addr=%0d: got lat=%0d err=%b, need %0d/0", b2b, i + 2, rd_lat, rd_err, EXP_LAT);
      end
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 4'(i + 2), 8'h00, b2b && (i != 3));
      n_vec++;
      if (rd_dat !== vals[i] || rd_lat !== EXP_LAT) begin
        n_err++;
        $display("FAIL rd_back b2b=%0d addr=%0d: got data=%h lat=%0d, need %h/%0d", b2b, i + 2, rd_dat, rd_lat, vals[i], EXP_LAT);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] exp8 [8];
    for (int i = 0; i < 8; i++) exp8[i] = 8'h00;
    exp8[2] = 8'd5; exp8[3] = 8'd10; exp8[4] = 8'd5; exp8[5] = 8'd10;
    xfer(1'b1, 4'd9, 8'hAA, 1'b0);
    n_vec++;
    if (rd_err8 !== 1'b1) begin
      n_err++;
      $display("FAIL unmapped_wr_err: got %b, need 1", rd_err8);
    end
    xfer(1'b0, 4'd9, 8'h00, 1'b0);
    n_vec++;
    if (rd_err8 !== 1'b1 || rd_dat8 !== 8'h00) begin
      n_err++;
      $display("FAIL unmapped_rd: got err=%b data=%h, need 1/00", rd_err8, rd_dat8);
    end
    n_vec++;
    if (rd_err !== 1'b0 || rd_dat !== 8'hAA) begin
      n_err++;
      $display("FAIL mapped16_rd9: got err=%b data=%h, need 0/aa", rd_err, rd_dat);
    end
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 4'(i), 8'h00, 1'b0);
      n_vec++;
      if (rd_dat8 !== exp8[i] || rd_err8 !== 1'b0) begin
        n_err++;
        $display("FAIL depth8_reg[%0d]: got data=%h err=%b, need %h/0", i, rd_dat8, rd_err8, exp8[i]);
      end
    end
  endtask

  task automatic test_abort_reset();
    xfer(1'b1, 4'd6, 8'h11, 1'b0);
    // Setup for a write of 33, then withdraw psel before the access phase completes.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd6; pwdata = 8'h33;
    @(posedge pclk); #1;
    psel = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    xfer(1'b0, 4'd6, 8'h00, 1'b0);
    n_vec++;
    if (rd_dat !== 8'h11) begin
      n_err++;
      $display("FAIL abort_wr: reg6 got %h, need 11", rd_dat);
    end
    // Reset pulse in the middle of a read of addr 2 (which holds 5).
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'd2;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2;
    n_vec++;
    if (prdata !== 8'd5) begin
      n_err++;
      $display("FAIL pre_reset_rdata: got %h, need 05", prdata);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (pready !== 1'b0 || prdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_abort: got pready=%b prdata=%h, need 0/00", pready, prdata);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 4'd2, 8'h00, 1'b0);
    n_vec++;
    if (rd_dat !== 8'h00) begin
      n_err++;
      $display("FAIL post_reset_rd2: got %h, need 00", rd_dat);
    end
  endtask

  task automatic test_protocol_violation();
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd7; pwdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      n_vec++;
      if (pready !== 1'b0) begin
        n_err++;
        $display("FAIL no_setup_pready cycle %0d: got %b, need 0", i, pready);
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(1'b0, 4'd7, 8'h00, 1'b0);
    n_vec++;
    if (rd_dat !== 8'h00) begin
      n_err++;
      $display("FAIL no_setup_write: reg7 got %h, need 00", rd_dat);
    end
  endtask

  initial begin
    test_reset();
    test_write_read(1'b0);
    test_write_read(1'b1);
    test_unmapped();
    test_abort_reset();
    test_protocol_violation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
